load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Bridges the MEM pipeline stage to the word-addressed data memory using a
//  valid/ready request and response handshake. Supports byte, halfword and word
//  loads and stores. Sign- or zero-extends loads. Builds sub-word stores as
//  read-modify-write sequences, because the data memory only writes whole words.
//  Rejects misaligned and out-of-range accesses without touching memory.
// PARAMETERS
//  MEM_WORDS  256  data memory depth in 32-bit words; word index >= MEM_WORDS is an error
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   unit can accept a request (IDLE only)
//  req_write     in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 reserved (error)
//  req_signed    in   1   loads: 1=sign-extend, 0=zero-extend
//  req_addr      in   32  byte address, little-endian
//  req_wdata     in   32  store data, right-justified
//  resp_valid    out  1   one-cycle response pulse
//  resp_err      out  1   qualifies resp_valid: misaligned/reserved/out-of-range
//  resp_rdata    out  32  load result; 0 for stores/errors; held until next response
//  mem_addr      out  32  word index to data memory (latched req_addr >> 2)
//  mem_wdata     out  32  write data to data memory
//  mem_memwrite  out  1   data memory write strobe
//  mem_memread   out  1   data memory read strobe
//  mem_rdata     in   32  data memory output; valid the cycle after mem_memread
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid, resp_err, mem_memread, mem_memwrite=0;
//    resp_rdata, mem_addr, mem_wdata=0. Async: strobes drop immediately.
//  Accept on req_valid&req_ready (cycle T). Latch all req_* fields.
//    The mem_* outputs depend only on state and latched fields, never on req_* inputs.
//  Error check at accept: half with addr[0]!=0, word with addr[1:0]!=0, size==11,
//    or addr[31:2]>=MEM_WORDS -> ERR. No mem strobe is ever asserted for the request.
//  FSM (one state per cycle):
//    IDLE -> ERR | LD_RD (load) | ST_WR (word store) | RMW_RD (byte/half store)
//    LD_RD: mem_memread=1 -> LD_CAP
//    LD_CAP: extract lane from mem_rdata, extend, register into resp_rdata -> DONE
//    RMW_RD: mem_memread=1 -> RMW_MRG
//    RMW_MRG: merge latched wdata lane into mem_rdata, register as mem_wdata -> ST_WR
//    ST_WR: mem_memwrite=1, mem_wdata = merged word or req_wdata -> DONE
//    DONE: resp_valid=1, resp_err=0 -> IDLE
//    ERR: resp_valid=1, resp_err=1, resp_rdata=0 -> IDLE
//  Lanes: byte k = bits[8k+7:8k], k=addr[1:0]. Half: addr[1]=0 -> [15:0], 1 -> [31:16].
//    Store lanes take req_wdata[7:0] / [15:0]; all other lanes keep the read value.
//  Latency, response cycle: load T+3, word store T+2, sub-word store T+4, error T+1.
//  req_ready=0 in every state except IDLE. A request held through DONE is accepted
//    in the cycle after DONE. No back-to-back overlap; one outstanding request.
//  Exactly one of mem_memread/mem_memwrite is high at a time. Both are low in IDLE/DONE/ERR.
//  Reset mid-operation aborts the request. No response is issued.
//    An RMW aborted before ST_WR leaves memory unmodified.
// TESTING  (memory power-up contents: word i = i)
//  LW 0x14, signed=0 -> mem_addr=5 in LD_RD; resp_valid at T+3 with resp_rdata=0x00000005.
//  SB 0x15 wdata=0xAB -> mem_memwrite at T+3 with mem_wdata=0x0000AB05;
//    then LBU 0x15 -> 0x000000AB, LB 0x15 -> 0xFFFFFFAB.
//  SH 0x1A wdata=0x8001 -> word 6=0x80010006; LH 0x1A -> 0xFFFF8001; LHU -> 0x00008001.
//  LW 0x02, LH 0x03, size=11, LW 0x400 -> each resp_err=1 at T+1, resp_rdata=0;
//    no mem strobe.
//  SB 0x20 with rst_n pulsed low during RMW_MRG -> strobes 0 at once, no resp_valid,
//    LW 0x20 afterward returns 0x00000008.
//  req_valid held high with two LW requests -> req_ready=0 T+1..T+3,
//    second accepted at T+4, response at T+7.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the MEM stage to a word-addressed data memory.
// Handles byte/half/word loads (sign or zero extended) and stores. Sub-word
// stores are read-modify-write because memory only writes whole words.
// Misaligned, reserved-size and out-of-range requests are rejected without
// any memory strobe.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_write/size/signed/addr/wdata request payload, latched at accept
//   resp_valid/resp_err/resp_rdata   one-cycle response, rdata held
//   mem_addr/wdata/memwrite/memread  data memory interface (word index)
//   mem_rdata                        memory read data, valid cycle after read
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DW = 32;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE, LD_RD, LD_CAP, RMW_RD, RMW_MRG, ST_WR, DONE, ERR
    } state_t;

    // Fields still needed after accept (address word index lives in mem_addr)
    typedef struct packed {
        logic [1:0]    size;
        logic          sgn;
        logic [1:0]    offs;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state_q, state_d;
    req_t          req_q, req_d;
    logic [DW-1:0] resp_rdata_d, mem_addr_d, mem_wdata_d;

    logic          err_c;
    logic [4:0]    shamt_c;
    logic [7:0]    lane_b_c;
    logic [15:0]   lane_h_c;
    logic [DW-1:0] load_c, mask_c, merged_c;

    // Request rejection decided from the live inputs at accept time
    always_comb begin
        err_c = 1'b0;
        if (req_size == 2'b11)                             err_c = 1'b1;
        if (req_size == SZ_H && req_addr[0])               err_c = 1'b1;
        if (req_size == SZ_W && req_addr[1:0] != 2'b00)    err_c = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))     err_c = 1'b1;
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        shamt_c  = {req_q.offs, 3'b000};
        lane_b_c = 8'(mem_rdata >> shamt_c);
        lane_h_c = 16'(mem_rdata >> shamt_c);
        case (req_q.size)
            SZ_B:    load_c = req_q.sgn ? {{24{lane_b_c[7]}}, lane_b_c} : {24'b0, lane_b_c};
            SZ_H:    load_c = req_q.sgn ? {{16{lane_h_c[15]}}, lane_h_c} : {16'b0, lane_h_c};
            default: load_c = mem_rdata;
        endcase
        mask_c   = (req_q.size == SZ_B) ? (32'h0000_00FF << shamt_c) : (32'h0000_FFFF << shamt_c);
        merged_c = (mem_rdata & ~mask_c) | ((req_q.wdata << shamt_c) & mask_c);
    end

    // Next-state and next-register values
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        resp_rdata_d = resp_rdata;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d      = '{size: req_size, sgn: req_signed,
                                   offs: req_addr[1:0], wdata: req_wdata};
                    mem_addr_d = {2'b00, req_addr[31:2]};
                    if (err_c) begin
                        state_d      = ERR;
                        resp_rdata_d = '0;
                    end else if (!req_write) begin
                        state_d = LD_RD;
                    end else if (req_size == SZ_W) begin
                        state_d     = ST_WR;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LD_RD:   state_d = LD_CAP;
            LD_CAP: begin
                state_d      = DONE;
                resp_rdata_d = load_c;
            end
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: begin
                state_d     = ST_WR;
                mem_wdata_d = merged_c;
            end
            ST_WR: begin
                state_d      = DONE;
                resp_rdata_d = '0;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; strobes derive from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_memwrite <= 1'b0;
            mem_memread  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_ready    <= (state_d == IDLE);
            resp_valid   <= (state_d == DONE) || (state_d == ERR);
            resp_err     <= (state_d == ERR);
            resp_rdata   <= resp_rdata_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_memwrite <= (state_d == ST_WR);
            mem_memread  <= (state_d == LD_RD) || (state_d == RMW_RD);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit with a synchronous 256-word memory model
// (word i = i at power-up) and a response scoreboard.
module tb_load_store_unit;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_memwrite, mem_memread;

    int total = 0;
    int bad   = 0;

    typedef struct { logic err; logic [31:0] rdata; } exp_t;
    typedef struct {
        logic got; int lat; logic err; logic [31:0] rdata;
        logic saw_rd; logic saw_wr; logic both;
        logic [31:0] wr_data; int wr_lat; logic [31:0] rd_addr;
        exp_t exp;
    } obs_t;
    typedef struct {
        logic wr; logic [1:0] sz; logic sg; logic [31:0] addr; logic [31:0] wd;
        logic err; logic [31:0] rd; int lat; logic [31:0] mw;
    } vec_t;

    exp_t sb[$];
    logic [31:0] mem [256];

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_memread && mem_addr < 256) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_memwrite && mem_addr < 256) mem[mem_addr[7:0]] <= mem_wdata;
    end

    // Drive one request, push its expectation, collect what the DUT does
    task automatic run_req(input vec_t v, output obs_t o);
        int   guard;
        exp_t e;
        o = '{got: 1'b0, lat: 0, err: 1'b0, rdata: '0, saw_rd: 1'b0, saw_wr: 1'b0,
              both: 1'b0, wr_data: '0, wr_lat: 0, rd_addr: '0, exp: '{1'b0, 32'h0}};
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_write = v.wr; req_size = v.sz; req_signed = v.sg;
        req_addr = v.addr; req_wdata = v.wd; req_valid = 1'b1;
        e.err = v.err; e.rdata = v.rd;
        sb.push_back(e);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (mem_memread) begin o.saw_rd = 1'b1; if (c == 1) o.rd_addr = mem_addr; end
            if (mem_memwrite) begin o.saw_wr = 1'b1; o.wr_data = mem_wdata; o.wr_lat = c; end
            if (mem_memread && mem_memwrite) o.both = 1'b1;
            if (resp_valid) begin
                o.got = 1'b1; o.lat = c; o.err = resp_err; o.rdata = resp_rdata;
                o.exp = sb.pop_front();
                break;
            end
        end
        if (!o.got && sb.size() > 0) o.exp = sb.pop_back();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        total++; if ({req_ready, resp_valid, resp_err, mem_memread, mem_memwrite} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=10000", {req_ready, resp_valid, resp_err, mem_memread, mem_memwrite}); end
        total++; if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0", resp_rdata, mem_addr, mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset ready=%b valid=%b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_load();
        vec_t v[4];
        obs_t o;
        v[0] = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0, 1'b0, 32'h0000_0005, 3, 32'h0};
        v[1] = '{1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0000_00FF, 3, 32'h0};
        v[2] = '{1'b0, 2'b00, 1'b1, 32'h3FC, 32'h0, 1'b0, 32'hFFFF_FFFF, 3, 32'h0};
        v[3] = '{1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0, 1'b0, 32'h0000_0000, 3, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_req(v[i], o);
            total++; if (!o.got || o.lat != v[i].lat) begin
                bad++; $display("FAIL load%0d_latency got=%0d want=%0d", i, o.lat, v[i].lat); end
            total++; if (o.err !== o.exp.err || o.rdata !== o.exp.rdata) begin
                bad++; $display("FAIL load%0d_resp got=%b/%h want=%b/%h", i, o.err, o.rdata, o.exp.err, o.exp.rdata); end
            total++; if (!o.saw_rd || o.saw_wr || o.both || o.rd_addr !== (v[i].addr >> 2)) begin
                bad++; $display("FAIL load%0d_mem rd=%b wr=%b addr=%h want addr=%h", i, o.saw_rd, o.saw_wr, o.rd_addr, v[i].addr >> 2); end
        end
    endtask

    task automatic test_sub_store();
        vec_t v[8];
        obs_t o;
        v[0] = '{1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00AB, 1'b0, 32'h0, 4, 32'h0000_AB05};
        v[1] = '{1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 1'b0, 32'h0000_00AB, 3, 32'h0};
        v[2] = '{1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 1'b0, 32'hFFFF_FFAB, 3, 32'h0};
        v[3] = '{1'b1, 2'b01, 1'b0, 32'h1A, 32'h0000_8001, 1'b0, 32'h0, 4, 32'h8001_0006};
        v[4] = '{1'b0, 2'b01, 1'b1, 32'h1A, 32'h0, 1'b0, 32'hFFFF_8001, 3, 32'h0};
        v[5] = '{1'b0, 2'b01, 1'b0, 32'h1A, 32'h0, 1'b0, 32'h0000_8001, 3, 32'h0};
        v[6] = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_567F, 1'b0, 32'h0, 4, 32'h7F00_0004};
        v[7] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_007F, 3, 32'h0};
        for (int i = 0; i < 8; i++) begin
            run_req(v[i], o);
            total++; if (!o.got || o.lat != v[i].lat) begin
                bad++; $display("FAIL sub%0d_latency got=%0d want=%0d", i, o.lat, v[i].lat); end
            total++; if (o.err !== o.exp.err || o.rdata !== o.exp.rdata) begin
                bad++; $display("FAIL sub%0d_resp got=%b/%h want=%b/%h", i, o.err, o.rdata, o.exp.err, o.exp.rdata); end
            if (v[i].wr) begin
                total++; if (!o.saw_wr || o.both || o.wr_lat != 3 || o.wr_data !== v[i].mw) begin
                    bad++; $display("FAIL sub%0d_write at=%0d data=%h want at=3 data=%h", i, o.wr_lat, o.wr_data, v[i].mw); end
            end
        end
        total++; if (mem[6] !== 32'h8001_0006) begin
            bad++; $display("FAIL word6 got=%h want=80010006", mem[6]); end
    endtask

    task automatic test_word_store();
        vec_t v[4];
        obs_t o;
        v[0] = '{1'b1, 2'b10, 1'b0, 32'h1C, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 32'hDEAD_BEEF};
        v[1] = '{1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, 32'h0};
        v[2] = '{1'b0, 2'b01, 1'b1, 32'h1E, 32'h0, 1'b0, 32'hFFFF_DEAD, 3, 32'h0};
        v[3] = '{1'b0, 2'b00, 1'b0, 32'h1C, 32'h0, 1'b0, 32'h0000_00EF, 3, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_req(v[i], o);
            total++; if (!o.got || o.lat != v[i].lat) begin
                bad++; $display("FAIL word%0d_latency got=%0d want=%0d", i, o.lat, v[i].lat); end
            total++; if (o.err !== o.exp.err || o.rdata !== o.exp.rdata) begin
                bad++; $display("FAIL word%0d_resp got=%b/%h want=%b/%h", i, o.err, o.rdata, o.exp.err, o.exp.rdata); end
            if (v[i].wr) begin
                total++; if (!o.saw_wr || o.saw_rd || o.wr_lat != 1 || o.wr_data !== v[i].mw) begin
                    bad++; $display("FAIL word%0d_write at=%0d data=%h want at=1 data=%h", i, o.wr_lat, o.wr_data, v[i].mw); end
            end
        end
    endtask

    task automatic test_errors();
        vec_t v[6];
        obs_t o;
        v[0] = '{1'b0, 2'b10, 1'b0, 32'h02,  32'h0, 1'b1, 32'h0, 1, 32'h0};
        v[1] = '{1'b0, 2'b01, 1'b1, 32'h03,  32'h0, 1'b1, 32'h0, 1, 32'h0};
        v[2] = '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0, 1'b1, 32'h0, 1, 32'h0};
        v[3] = '{1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1, 32'h0};
        v[4] = '{1'b1, 2'b01, 1'b0, 32'h01,  32'hFFFF, 1'b1, 32'h0, 1, 32'h0};
        v[5] = '{1'b1, 2'b00, 1'b0, 32'h400, 32'hFF, 1'b1, 32'h0, 1, 32'h0};
        for (int i = 0; i < 6; i++) begin
            run_req(v[i], o);
            total++; if (!o.got || o.lat != v[i].lat) begin
                bad++; $display("FAIL err%0d_latency got=%0d want=%0d", i, o.lat, v[i].lat); end
            total++; if (o.err !== o.exp.err || o.rdata !== o.exp.rdata) begin
                bad++; $display("FAIL err%0d_resp got=%b/%h want=%b/%h", i, o.err, o.rdata, o.exp.err, o.exp.rdata); end
            total++; if (o.saw_rd || o.saw_wr) begin
                bad++; $display("FAIL err%0d_strobe rd=%b wr=%b want 0/0", i, o.saw_rd, o.saw_wr); end
        end
    endtask

    task automatic test_reset_abort();
        vec_t v;
        obs_t o;
        logic seen;
        int   guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h5A; req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({mem_memread, mem_memwrite, resp_valid} !== 3'b000) begin
            bad++; $display("FAIL abort_strobes got=%b want=000", {mem_memread, mem_memwrite, resp_valid}); end
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid || mem_memwrite) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid || mem_memwrite) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin
            bad++; $display("FAIL abort_activity got=%b want=0", seen); end
        v = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0000_0008, 3, 32'h0};
        run_req(v, o);
        total++; if (!o.got || o.rdata !== o.exp.rdata || o.lat != 3) begin
            bad++; $display("FAIL abort_reload got=%h lat=%0d want=%h lat=3", o.rdata, o.lat, o.exp.rdata); end
    endtask

    task automatic test_back_to_back();
        exp_t e, p;
        int   lat1 = 0, lat2 = 0, n = 0;
        logic ready_bad = 1'b0, ready4 = 1'b0, ready5 = 1'b1;
        logic [31:0] rd1 = '0, rd2 = '0;
        exp_t e1, e2;
        e1 = '{1'b0, 32'h0}; e2 = '{1'b0, 32'h0};
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h24; req_valid = 1'b1;
        e.err = 1'b0; e.rdata = 32'h0000_0009;  sb.push_back(e);
        e.err = 1'b0; e.rdata = 32'h0000_000A;  sb.push_back(e);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) req_addr = 32'h28;
            if (c >= 1 && c <= 3 && req_ready) ready_bad = 1'b1;
            if (c == 4) ready4 = req_ready;
            if (c == 5) begin ready5 = req_ready; req_valid = 1'b0; end
            if (resp_valid) begin
                p = sb.pop_front();
                n++;
                if (n == 1) begin lat1 = c; rd1 = resp_rdata; e1 = p; end
                else begin lat2 = c; rd2 = resp_rdata; e2 = p; end
            end
            if (n == 2) break;
        end
        total++; if (ready_bad) begin
            bad++; $display("FAIL b2b_busy_ready got=1 want=0 during T+1..T+3"); end
        total++; if (ready4 !== 1'b1 || ready5 !== 1'b0) begin
            bad++; $display("FAIL b2b_second_accept ready4=%b ready5=%b want 1/0", ready4, ready5); end
        total++; if (lat1 != 3 || rd1 !== e1.rdata) begin
            bad++; $display("FAIL b2b_first got lat=%0d %h want lat=3 %h", lat1, rd1, e1.rdata); end
        total++; if (lat2 != 7 || rd2 !== e2.rdata) begin
            bad++; $display("FAIL b2b_second got lat=%0d %h want lat=7 %h", lat2, rd2, e2.rdata); end
        while (sb.size() > 0) p = sb.pop_front();
    endtask

    // Exclusive strobes at all times outside reset
    always @(negedge clk) begin
        if (rst_n && mem_memread && mem_memwrite) begin
            total++; bad++;
            $display("FAIL strobe_overlap rd=1 wr=1 want at most one");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load();
        test_sub_store();
        test_word_store();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
